// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared sequencer state encoding and PE geometry defaults.
package pe_ctrl_pkg;
  localparam int PE_INST_W = 28;
  localparam int PE_BUF_DEPTH = 16;
  localparam int PE_DRAIN_CYC = 2;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;
endpackage

// File: rtl/pe_load_addr_gen.sv
// pe_load_addr_gen: context/PE counters for config loading, last-word flag and
// one-hot PE select for the word currently being accepted.
module pe_load_addr_gen #(
  parameter int NUM_PE    = 16,
  parameter int BUF_DEPTH = 16,
  parameter int NW        = $clog2(BUF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [NW-1:0]     num,
  output logic [NUM_PE-1:0] init_oh,
  output logic              last
);
  localparam int CXW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int PW  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  logic [CXW-1:0] ctx_q, ctx_d;
  logic [PW-1:0]  pe_idx_q, pe_idx_d;
  logic           ctx_end, pe_end;
  always_comb begin
    ctx_end  = ctx_q == CXW'(num - NW'(1));
    pe_end   = pe_idx_q == PW'(NUM_PE - 1);
    ctx_d    = clr ? '0 : adv ? (ctx_end ? '0 : ctx_q + CXW'(1)) : ctx_q;
    pe_idx_d = clr ? '0 : (adv && ctx_end) ? (pe_end ? '0 : pe_idx_q + PW'(1)) : pe_idx_q;
  end
  assign init_oh = NUM_PE'(1) << pe_idx_q;
  assign last    = ctx_end && pe_end;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctx_q    <= '0;
      pe_idx_q <= '0;
    end else begin
      ctx_q    <= ctx_d;
      pe_idx_q <= pe_idx_d;
    end
  end
endmodule

// File: rtl/pe_array_cfg_ctrl.sv
// pe_array_cfg_ctrl: clear/load/run/drain sequencer for a PE array.
// Optional PE_CFG_TIMEOUT_EN adds an idle-stream watchdog in LOAD that acts as abort.
module pe_array_cfg_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_PE    = 16,
  parameter int INST_W    = PE_INST_W,
  parameter int BUF_DEPTH = PE_BUF_DEPTH,
  parameter int DRAIN_CYC = PE_DRAIN_CYC,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(BUF_DEPTH):0]   num_inst,
  input  logic                         cfg_valid,
  input  logic [INST_W-1:0]            cfg_data,
  output logic                         cfg_ready,
  output logic                         pe_clr,
  output logic [INST_W-1:0]            pe_inst,
  output logic [NUM_PE-1:0]            pe_init,
  output logic                         pe_run,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int NW = $clog2(BUF_DEPTH) + 1;
  localparam int CW = $clog2(BUF_DEPTH + DRAIN_CYC + 1) + 1;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NW-1:0]      num_q, num_d;
  logic               cfg_ready_q, cfg_ready_d, pe_clr_q, pe_clr_d, pe_run_q, pe_run_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [INST_W-1:0]  pe_inst_q, pe_inst_d;
  logic [NUM_PE-1:0]  pe_init_q, pe_init_d, init_oh;
  logic               hs, acc, kill, tmo, num_ok, last;
  pe_load_addr_gen #(.NUM_PE(NUM_PE), .BUF_DEPTH(BUF_DEPTH), .NW(NW)) u_addr (
    .clk(clk), .rst(rst), .clr(state_q == S_CLEAR), .adv(acc), .num(num_q),
    .init_oh(init_oh), .last(last)
  );
`ifdef PE_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  always_comb begin
    to_d = (state_q == S_LOAD && !hs) ? to_q + TW'(1) : '0;
  end
  assign tmo = state_q == S_LOAD && !hs && to_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst) to_q <= '0;
    else      to_q <= to_d;
  end
`else
  assign tmo = TIMEOUT < 0;
`endif
  always_comb begin
    hs     = cfg_valid && cfg_ready_q;
    kill   = (abort && state_q != S_IDLE) || tmo;
    acc    = hs && !kill;
    num_ok = num_inst != '0 && num_inst <= NW'(BUF_DEPTH);
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      S_IDLE:  if (start && num_ok) begin
                 state_d = S_CLEAR;
                 num_d   = num_inst;
               end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:  if (hs && last) begin
                 state_d = S_RUN;
                 cnt_d   = '0;
               end
      S_RUN:   begin
                 cnt_d = cnt_q + CW'(1);
                 if (cnt_q == CW'(num_q) - CW'(1)) begin
                   state_d = S_DRAIN;
                   cnt_d   = '0;
                 end
               end
      S_DRAIN: begin
                 cnt_d = cnt_q + CW'(1);
                 if (cnt_q == CW'(DRAIN_CYC)) state_d = S_DONE;
               end
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
    // pe_run lags RUN by one cycle so it starts right after the last pe_init
    pe_run_d    = state_q == S_RUN && !kill;
    pe_clr_d    = state_d == S_CLEAR || kill;
    err_d       = (state_q == S_IDLE && start && !num_ok) || kill;
    cfg_ready_d = state_d == S_LOAD;
    busy_d      = state_d != S_IDLE;
    done_d      = state_d == S_DONE;
    pe_init_d   = acc ? init_oh : '0;
    pe_inst_d   = acc ? cfg_data : pe_inst_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      cfg_ready_q <= 1'b0;
      pe_clr_q    <= 1'b0;
      pe_run_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pe_inst_q   <= '0;
      pe_init_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      cfg_ready_q <= cfg_ready_d;
      pe_clr_q    <= pe_clr_d;
      pe_run_q    <= pe_run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pe_inst_q   <= pe_inst_d;
      pe_init_q   <= pe_init_d;
    end
  end
  assign cfg_ready = cfg_ready_q;
  assign pe_clr    = pe_clr_q;
  assign pe_inst   = pe_inst_q;
  assign pe_init   = pe_init_q;
  assign pe_run    = pe_run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_pe_array_cfg_ctrl.sv
// tb_pe_array_cfg_ctrl: scoreboard bench for pe_array_cfg_ctrl (NUM_PE=4).
// Stimulus queues expected strobe events; a negedge monitor checks order, payload and spacing.
module tb_pe_array_cfg_ctrl;
  localparam int NP = 4, IW = 28, BD = 16, NW = 5;
  logic clk = 0, rst = 0, start = 0, abort = 0, cfg_valid = 0;
  logic [NW-1:0] num_inst = '0;
  logic [IW-1:0] cfg_data = '0;
  logic cfg_ready, pe_clr, pe_run, busy, done, err;
  logic [IW-1:0] pe_inst;
  logic [NP-1:0] pe_init;
  bit abort_with_start = 0;
  pe_array_cfg_ctrl #(.NUM_PE(NP), .INST_W(IW), .BUF_DEPTH(BD), .DRAIN_CYC(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_inst(num_inst),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .pe_clr(pe_clr),
    .pe_inst(pe_inst), .pe_init(pe_init), .pe_run(pe_run), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [35:0] v; int gap;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, gap = 0;
  logic [35:0] obs;
  exp_t e;
  // event = {clr,err,done,run, init[3:0], inst}; inst compared only for init events; gap 0 = any spacing
  always @(negedge clk) if (rst) begin
    gap = gap + 1;
    obs = {pe_clr, err, done, pe_run, pe_init, pe_inst};
    if (|obs[35:28]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%h", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs[35:28] !== e.v[35:28] || (|e.v[31:28] && obs[27:0] !== e.v[27:0]) ||
            (e.gap != 0 && gap != e.gap)) begin
          errors++;
          $display("FAIL sb_event got=%h gap=%0d exp=%h gap=%0d", obs, gap, e.v, e.gap);
        end
      end
      gap = 0;
    end
  end
  function automatic logic [IW-1:0] wd(int s, int p, int c);
    logic [7:0] sb = s[7:0];
    logic [3:0] pb = p[3:0];
    logic [3:0] cb = c[3:0];
    return {4'hA, sb, 8'h5C, pb, cb};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [3:0] ctl, logic [3:0] init, logic [IW-1:0] inst, int g);
    exp_t x;
    x.v = {ctl, init, inst};
    x.gap = g;
    exp_q.push_back(x);
  endtask
  task automatic push_load(int n, int s, int lim);
    push(4'b1000, 4'b0, '0, 0);
    for (int i = 0; i < lim; i++) push(4'b0000, 4'(1 << (i / n)), wd(s, i / n, i % n), 0);
  endtask
  task automatic feed(int n, bit mode, int lim, int s);
    int idx = 0, cyc = 0;
    bit tog = 0, h;
    start = 1; abort = abort_with_start; num_inst = NW'(n);
    step();
    start = 0; abort = 0;
    while (idx < lim && cyc < 500) begin
      cfg_data = wd(s, idx / n, idx % n);
      cfg_valid = !mode || tog;
      h = cfg_valid && cfg_ready;
      step();
      cyc++; tog = !tog;
      if (h) idx++;
    end
    chk("feed_count", idx, lim);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    chk("idle_bound", busy, 0);
  endtask
  task automatic seq(int n, bit mode, int s, int ab);
    int total = NP * n;
    push_load(n, s, total);
    if (ab == 0) begin
      for (int r = 0; r < n; r++) push(4'b0001, 4'b0, '0, 1);
      push(4'b0010, 4'b0, '0, 3);
    end else begin
      for (int r = 0; r < ab; r++) push(4'b0001, 4'b0, '0, 1);
      push(4'b1100, 4'b0, '0, 1);
    end
    feed(n, mode, total, s);
    cfg_valid = 1; cfg_data = '1;
    chk("no_extra_word", cfg_ready, 0);
    if (ab == 0) begin
      step();
      cfg_valid = 0;
      wait_idle();
    end else begin
      for (int k = 1; k <= ab; k++) begin
        step();
        cfg_valid = 0; num_inst = 5;
        start = (k == 1 && ab >= 2);
        abort = (k == ab);
      end
      step();
      start = 0; abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", cfg_ready, 0);
    end
    step(); step();
    chk("sb_empty", exp_q.size(), 0);
  endtask
  task automatic bad_start(int n);
    push(4'b0100, 4'b0, '0, 0);
    start = 1; num_inst = NW'(n);
    step();
    start = 0;
    chk("bad_start_busy", busy, 0);
    step(); step();
    chk("bad_start_sb", exp_q.size(), 0);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_outs", {pe_clr, err, done, pe_run, cfg_ready, busy, pe_init}, 0);
    chk("rst_inst", pe_inst, 0);
    rst = 1;
    step();
    // T1: reset in the middle of loading
    push_load(2, 1, 3);
    feed(2, 0, 3, 1);
    cfg_valid = 0;
    step();
    rst = 0;
    step();
    rst = 1;
    chk("t1_outs", {pe_clr, err, done, pe_run, cfg_ready, busy, pe_init}, 0);
    chk("t1_inst", pe_inst, 0);
    chk("t1_sb", exp_q.size(), 0);
    // T2: continuous stream
    seq(3, 0, 2, 0);
    // T3: toggling valid; abort alongside start in IDLE must lose to start
    abort_with_start = 1;
    seq(3, 1, 3, 0);
    abort_with_start = 0;
    // T4: num_inst bounds
    bad_start(0);
    bad_start(BD + 1);
    seq(BD, 0, 4, 0);
    abort = 1;
    step();
    abort = 0;
    chk("idle_abort_busy", busy, 0);
    step(); step();
    chk("idle_abort_sb", exp_q.size(), 0);
    // T5: abort two cycles into RUN, start while busy ignored
    seq(4, 0, 5, 2);
    seq(2, 1, 6, 0);
`ifdef PE_CFG_TIMEOUT_EN
    // T6: watchdog fires after 8 idle LOAD cycles
    push(4'b1000, 4'b0, '0, 0);
    push(4'b1100, 4'b0, '0, 9);
    start = 1; num_inst = 1;
    step();
    start = 0;
    wait_idle();
    step(); step();
    chk("timeout_sb", exp_q.size(), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
